// File: rtl/audio_mixer_mac.sv
// audio_mixer_mac: multi-channel stereo mixer. Each frame it snapshots the
// inputs and accumulates sample*volume for one channel per clock into the
// left and right accumulators. It then applies a master gain and saturates
// the results. The master gain ramps by one step per frame: down while mute
// is high, up otherwise.
// Optional build macro: MIXER_DC_BLOCK_EN adds a first-order DC-blocking
// filter after saturation, with no change in latency.
// Handshake: strobe is a one-cycle request that is accepted only in IDLE.
// valid is a one-cycle pulse and the audio outputs are held until the next
// valid. busy covers the whole frame, from acceptance to the valid cycle.
module audio_mixer_mac #(
    parameter int NCH   = 8,
    parameter int IN_W  = 16,
    parameter int VOL_W = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strobe,
    input  logic [NCH*IN_W-1:0]     samples,
    input  logic [NCH*VOL_W-1:0]    vol_l,
    input  logic [NCH*VOL_W-1:0]    vol_r,
    input  logic                    mute,
    output logic signed [OUT_W-1:0] audio_l,
    output logic signed [OUT_W-1:0] audio_r,
    output logic                    valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACC_W = IN_W + VOL_W + $clog2(NCH) + 1;
    localparam int SC_W  = ACC_W + VOL_W + 2;
    localparam int CH_W  = $clog2(NCH);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
    localparam logic [VOL_W:0]   GAIN_MAX = {1'b1, {VOL_W{1'b0}}};
    localparam logic signed [SC_W-1:0] SAT_MAX = SC_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [SC_W-1:0] SAT_MIN = -SAT_MAX - SC_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                    state, state_nx;
    logic [CH_W-1:0]           ch;
    logic [NCH*IN_W-1:0]       snap_samples;
    logic [NCH*VOL_W-1:0]      snap_vol_l, snap_vol_r;
    logic signed [ACC_W-1:0]   acc_l, acc_r;
    logic [VOL_W:0]            gain;
    logic signed [SC_W-1:0]    scaled_l, scaled_r;

    logic signed [IN_W-1:0]    cur_s;
    logic signed [ACC_W-1:0]   prod_l, prod_r;
    logic signed [SC_W-1:0]    g_ext, sc_l, sc_r;
    logic signed [OUT_W-1:0]   sat_l, sat_r, fin_l, fin_r;

    // Clamp a wide signed value into the OUT_W output range.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [SC_W-1:0] x);
        if (x > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
        else if (x < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
        else                  sat = x[OUT_W-1:0];
    endfunction

    // Frame sequencing: a fixed walk through the states once a frame is accepted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (strobe) state_nx = ACCUM;
            ACCUM:   if (ch == CH_LAST) state_nx = SCALE;
            SCALE:   state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: per-channel products, gain scaling, and saturation.
    always_comb begin
        cur_s  = $signed(snap_samples[ch*IN_W +: IN_W]);
        prod_l = ACC_W'(cur_s) * ACC_W'($signed({1'b0, snap_vol_l[ch*VOL_W +: VOL_W]}));
        prod_r = ACC_W'(cur_s) * ACC_W'($signed({1'b0, snap_vol_r[ch*VOL_W +: VOL_W]}));
        g_ext  = SC_W'($signed({1'b0, gain}));
        sc_l   = (SC_W'(acc_l >>> (VOL_W - 1)) * g_ext) >>> VOL_W;
        sc_r   = (SC_W'(acc_r >>> (VOL_W - 1)) * g_ext) >>> VOL_W;
        sat_l  = sat(scaled_l);
        sat_r  = sat(scaled_r);
    end

`ifdef MIXER_DC_BLOCK_EN
    logic signed [OUT_W-1:0] x_prev_l, x_prev_r, y_prev_l, y_prev_r;

    // DC blocker: y = x - x_prev + y_prev - y_prev/256, re-saturated.
    always_comb begin
        fin_l = sat(SC_W'(sat_l) - SC_W'(x_prev_l) + SC_W'(y_prev_l) - SC_W'(y_prev_l >>> 8));
        fin_r = sat(SC_W'(sat_r) - SC_W'(x_prev_r) + SC_W'(y_prev_r) - SC_W'(y_prev_r >>> 8));
    end

    // Filter history advances once per frame, when the outputs update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_l <= '0;
            x_prev_r <= '0;
            y_prev_l <= '0;
            y_prev_r <= '0;
        end else if (state == OUT) begin
            x_prev_l <= sat_l;
            x_prev_r <= sat_r;
            y_prev_l <= fin_l;
            y_prev_r <= fin_r;
        end
    end
`else
    // No filter: the saturated result goes straight to the outputs.
    always_comb begin
        fin_l = sat_l;
        fin_r = sat_r;
    end
`endif

    assign busy = (state != IDLE) || valid;

    // State, snapshot, accumulators, gain ramp and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            snap_samples <= '0;
            snap_vol_l   <= '0;
            snap_vol_r   <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            gain         <= '0;
            scaled_l     <= '0;
            scaled_r     <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state   <= state_nx;
            valid   <= (state == OUT);
            overrun <= strobe && (state != IDLE);
            case (state)
                IDLE: if (strobe) begin
                    snap_samples <= samples;
                    snap_vol_l   <= vol_l;
                    snap_vol_r   <= vol_r;
                    acc_l        <= '0;
                    acc_r        <= '0;
                    ch           <= '0;
                end
                ACCUM: begin
                    acc_l <= acc_l + prod_l;
                    acc_r <= acc_r + prod_r;
                    if (ch != CH_LAST) ch <= ch + CH_W'(1);
                end
                SCALE: begin
                    scaled_l <= sc_l;
                    scaled_r <= sc_r;
                end
                OUT: begin
                    audio_l <= fin_l;
                    audio_r <= fin_r;
                    if (mute) begin
                        if (gain != '0) gain <= gain - (VOL_W+1)'(1);
                    end else begin
                        if (gain != GAIN_MAX) gain <= gain + (VOL_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer_mac.sv
// Testbench for audio_mixer_mac with its default parameters (8 channels,
// 16-bit samples, 8-bit volumes) and the default build.
module tb_audio_mixer_mac;

  localparam int NCH = 8;
  localparam int SW  = NCH * 16;
  localparam int VW  = NCH * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          strobe;
  logic [SW-1:0] samples;
  logic [VW-1:0] vol_l, vol_r;
  logic          mute;
  logic [15:0]   audio_l, audio_r;
  logic          valid, busy, overrun;

  int n_checks = 0;
  int n_err = 0;
  int model_gain = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [SW-1:0] s;
    logic [VW-1:0] vl;
    logic [VW-1:0] vr;
    logic [15:0]   el;
    logic [15:0]   er;
  } vec_t;
  vec_t vecs[8];

  audio_mixer_mac dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .samples(samples),
    .vol_l(vol_l), .vol_r(vol_r), .mute(mute), .audio_l(audio_l),
    .audio_r(audio_r), .valid(valid), .busy(busy), .overrun(overrun)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: weighted sum, drop to unity scale, master gain (0..256)/256,
  // floor rounding throughout, clamp to 16-bit signed.
  function automatic logic [15:0] model_mix(input logic [SW-1:0] s, input logic [VW-1:0] v, input int g);
    longint acc, r;
    logic [15:0] sv;
    logic [7:0]  vv;
    acc = 0;
    for (int i = 0; i < NCH; i++) begin
      sv = s[i*16 +: 16];
      vv = v[i*8 +: 8];
      acc += longint'($signed(sv)) * longint'({56'd0, vv});
    end
    r = ((acc >>> 7) * longint'(g)) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [SW-1:0] rand_s();
    logic [SW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*16 +: 16] = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_v();
    logic [VW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic update_gain();
    if (mute) begin
      if (model_gain > 0) model_gain--;
    end else if (model_gain < 256) begin
      model_gain++;
    end
  endtask

  // One complete frame: request, scramble inputs after the snapshot, wait for valid.
  task automatic run_frame(input logic [SW-1:0] s, input logic [VW-1:0] vl, input logic [VW-1:0] vr,
                           output logic [15:0] ol, output logic [15:0] orr);
    int n;
    logic [31:0] e;
    samples = s;
    vol_l   = vl;
    vol_r   = vr;
    strobe  = 1'b1;
    exp_q.push_back({model_mix(s, vl, model_gain), model_mix(s, vr, model_gain)});
    tick();
    strobe  = 1'b0;
    samples = rand_s();
    vol_l   = rand_v();
    vol_r   = rand_v();
    check("busy_start", 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, NCH + 2);
    check("busy_valid", 32'(busy), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("audio_l", 32'(audio_l), 32'(e[31:16]));
      check("audio_r", 32'(audio_r), 32'(e[15:0]));
    end
    ol  = audio_l;
    orr = audio_r;
    update_gain();
  endtask

  initial begin
    logic [15:0] ol, orr;
    logic [SW-1:0] s_a, s_b;
    logic [VW-1:0] v_a;
    int cnt;
    logic [15:0] cap_l;

    // Table: all vectors assume full master gain.
    for (int i = 0; i < 8; i++) begin
      vecs[i].s = '0; vecs[i].vl = '0; vecs[i].vr = '0;
    end
    vecs[0].s[15:0] = 16'h1000; vecs[0].vl[7:0] = 8'h80;
    vecs[0].el = 16'h1000; vecs[0].er = 16'h0000;
    vecs[1].s = {NCH{16'h7FFF}}; vecs[1].vl = {NCH{8'hFF}}; vecs[1].vr = {NCH{8'hFF}};
    vecs[1].el = 16'h7FFF; vecs[1].er = 16'h7FFF;
    vecs[2].s = {NCH{16'h8000}}; vecs[2].vl = {NCH{8'hFF}}; vecs[2].vr = {NCH{8'hFF}};
    vecs[2].el = 16'h8000; vecs[2].er = 16'h8000;
    vecs[3].s[63:48] = 16'hE000; vecs[3].vl[31:24] = 8'h40; vecs[3].vr[31:24] = 8'h80;
    vecs[3].el = 16'hF000; vecs[3].er = 16'hE000;
    vecs[4].s[15:0] = 16'h0001; vecs[4].vl[7:0] = 8'h01; vecs[4].vr[7:0] = 8'h01;
    vecs[4].el = 16'h0000; vecs[4].er = 16'h0000;
    vecs[5].s[15:0] = 16'hFFFF; vecs[5].vl[7:0] = 8'h01;
    vecs[5].el = 16'hFFFF; vecs[5].er = 16'h0000;
    vecs[6].s[127:112] = 16'h7FFF; vecs[6].vl[63:56] = 8'h80; vecs[6].vr[63:56] = 8'h40;
    vecs[6].el = 16'h7FFF; vecs[6].er = 16'h3FFF;
    vecs[7].s[31:0] = {16'h4000, 16'h4000}; vecs[7].vl[15:0] = 16'h8080; vecs[7].vr[15:0] = 16'h4080;
    vecs[7].el = 16'h7FFF; vecs[7].er = 16'h6000;

    // Reset.
    rst_n = 1'b0; strobe = 1'b0; mute = 1'b0;
    samples = '0; vol_l = '0; vol_r = '0;
    repeat (3) tick();
    check("rst_audio_l", 32'(audio_l), 32'd0);
    check("rst_audio_r", 32'(audio_r), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fade-in: the first frame runs at gain 0, then 255 random frames ramp up.
    run_frame(vecs[0].s, vecs[0].vl, vecs[0].vr, ol, orr);
    check("first_frame_l", 32'(ol), 32'd0);
    for (int k = 0; k < 255; k++) run_frame(rand_s(), rand_v(), rand_v(), ol, orr);

    // Table at full gain.
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].s, vecs[i].vl, vecs[i].vr, ol, orr);
      check($sformatf("vec%0d_l", i), 32'(ol), 32'(vecs[i].el));
      check($sformatf("vec%0d_r", i), 32'(orr), 32'(vecs[i].er));
    end

    // Random frames at full gain.
    for (int k = 0; k < 20; k++) run_frame(rand_s(), rand_v(), rand_v(), ol, orr);

    // Strobe three clocks after a frame starts: overrun, one valid, first snapshot wins.
    s_a = rand_s(); v_a = rand_v(); s_b = rand_s();
    samples = s_a; vol_l = v_a; vol_r = v_a; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(); tick();
    samples = s_b; vol_l = rand_v(); strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check("overrun_pulse", 32'(overrun), 32'd1);
    tick();
    check("overrun_clear", 32'(overrun), 32'd0);
    cnt = 0; cap_l = '0;
    for (int k = 0; k < 15; k++) begin
      if (valid) begin cnt++; cap_l = audio_l; end
      tick();
    end
    check("overrun_single_valid", cnt, 1);
    check("overrun_result", 32'(cap_l), 32'(model_mix(s_a, v_a, model_gain)));
    update_gain();

    // Strobe during the output cycle is an overrun and starts nothing.
    s_a = rand_s(); v_a = rand_v();
    samples = s_a; vol_l = v_a; vol_r = v_a; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (NCH + 1) tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check("out_cycle_valid", 32'(valid), 32'd1);
    check("out_cycle_overrun", 32'(overrun), 32'd1);
    check("out_cycle_result", 32'(audio_r), 32'(model_mix(s_a, v_a, model_gain)));
    update_gain();
    tick();
    check("out_cycle_no_frame", 32'(busy), 32'd0);

    // Soft mute ramp down to silence, then back up to unity.
    s_a = '0; s_a[15:0] = 16'h1000;
    v_a = '0; v_a[7:0] = 8'h80;
    mute = 1'b1;
    for (int k = 0; k < 257; k++) begin
      run_frame(s_a, v_a, v_a, ol, orr);
      if (k == 1) check("mute_step", 32'(ol), 32'h0FF0);
    end
    check("mute_floor", 32'(ol), 32'd0);
    mute = 1'b0;
    for (int k = 0; k < 257; k++) run_frame(s_a, v_a, v_a, ol, orr);
    check("unmute_restore_l", 32'(ol), 32'h1000);
    check("unmute_restore_r", 32'(orr), 32'h1000);

    // Reset in the middle of accumulation.
    samples = s_a; vol_l = v_a; vol_r = v_a; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_audio_l", 32'(audio_l), 32'd0);
    check("midrst_audio_r", 32'(audio_r), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    exp_q.delete();
    model_gain = 0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (valid) cnt++;
      tick();
    end
    check("midrst_no_valid", cnt, 0);
    run_frame(s_a, v_a, v_a, ol, orr);
    check("post_rst_zero", 32'(ol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer_mac.md
AUDIO_MIXER_MAC -- requirements
Module: audio_mixer_mac

Interface
REQ-001 SHALL have parameter NCH, default 8, number of input channels (2..32).
REQ-002 SHALL have parameter IN_W, default 16, signed sample width per channel.
REQ-003 SHALL have parameter VOL_W, default 8, unsigned per-channel volume width; 2^(VOL_W-1) = unity gain.
REQ-004 SHALL have parameter OUT_W, default 16, signed output width (OUT_W <= IN_W+1).
REQ-005 SHALL have port clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port strobe  input  1  frame start request, one-cycle pulse.
REQ-008 SHALL have port samples  input  NCH*IN_W  packed signed samples, channel 0 in LSBs.
REQ-009 SHALL have port vol_l  input  NCH*VOL_W  packed left volumes.
REQ-010 SHALL have port vol_r  input  NCH*VOL_W  packed right volumes.
REQ-011 SHALL have port mute  input  1  soft-mute request (level).
REQ-012 SHALL have port audio_l  output  OUT_W  signed left result, registered.
REQ-013 SHALL have port audio_r  output  OUT_W  signed right result, registered.
REQ-014 SHALL have port valid  output  1  one-cycle pulse when audio_l/audio_r update.
REQ-015 SHALL have port busy  output  1  high while a frame is in progress.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when strobe arrives while busy.

Function
REQ-017 SHALL implement states IDLE, ACCUM, SCALE, OUT; OUT returns to IDLE unconditionally.
REQ-018 In IDLE, strobe=1 SHALL snapshot samples, vol_l, vol_r, clear both accumulators, set channel index to 0, enter ACCUM.
REQ-019 ACCUM SHALL add signed(sample[ch]) * unsigned(vol[ch]) into each side's accumulator, one channel per cycle, ch 0..NCH-1, then enter SCALE.
REQ-020 Accumulators SHALL be IN_W+VOL_W+clog2(NCH)+1 bits wide; no overflow possible during ACCUM.
REQ-021 SCALE SHALL compute (acc >>> (VOL_W-1)) * gain >>> VOL_W, arithmetic shifts, truncation toward minus infinity.
REQ-022 OUT SHALL saturate each result to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register to audio_l/audio_r, pulse valid.
REQ-023 valid SHALL assert exactly NCH+2 clocks after the edge sampling strobe; busy high from that edge until valid cycle inclusive.
REQ-024 Master gain register SHALL be VOL_W+1 bits, range 0..2^VOL_W; updated once per frame in OUT: mute=1 decrement by 1 (floor 0), mute=0 increment by 1 (ceiling 2^VOL_W).
REQ-025 strobe while busy SHALL be ignored (snapshot unchanged) and SHALL pulse overrun next cycle.
REQ-026 strobe in the OUT cycle SHALL count as busy (overrun); strobe in IDLE the cycle after OUT SHALL start a new frame.
REQ-027 Input changes after snapshot SHALL NOT affect the current frame.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, audio_l=0, audio_r=0, valid=0, busy=0, overrun=0, accumulators=0, gain=0 (fade-in after reset).
REQ-029 Reset mid-frame SHALL discard the frame; no valid pulse for it.

Configuration
REQ-030 Macro MIXER_DC_BLOCK_EN defined: each side's saturated result x SHALL pass y=x-x_prev+y_prev-(y_prev>>>8), updated per frame, re-saturated to OUT_W, state reset to 0; same latency.
REQ-031 Macro MIXER_DC_BLOCK_EN undefined: saturated result SHALL drive outputs directly, no filter state.

Verification
REQ-032 Defaults, mute=0, 256 frames after reset; ch0=0x1000, vol_l0=0x80, vol_r0=0, others 0 -> audio_l=0x1000, audio_r=0x0000, valid 10 clocks after strobe.
REQ-033 Full gain; all channels 0x7FFF, volumes 0xFF -> audio_l=audio_r=0x7FFF; all 0x8000 -> 0x8000.
REQ-034 Full gain, ch0=0x1000 unity both sides, mute=1 -> each frame output drops by 0x0010; 0x0000 after 256 frames; mute=0 restores 0x1000 after 256 frames.
REQ-035 strobe 3 clocks after a frame start -> overrun pulse one cycle later, single valid only, result equals first snapshot.
REQ-036 rst_n low during ACCUM -> outputs 0, busy 0 immediately; no valid; first post-reset frame output 0x0000 (gain 0).
REQ-037 MIXER_DC_BLOCK_EN defined, constant 0x1000 unity at full gain -> first output 0x1000, then monotonic decay toward 0x0000.
